// File: rtl/dot_product_acc_pkg.sv
// Shared types and widths for the dot-product accumulator.
// Holds the controller state encoding and the operand/product widths.
package dot_product_acc_pkg;

   localparam int OPND_W      = 4;
   localparam int PROD_W      = 8;
   localparam int DEF_VEC_LEN = 8;
   localparam int DEF_ACC_W   = 12;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/multiplier_4_x_4.sv
// Unsigned 4x4 combinational multiplier.
// The result is the full 8-bit product, so nothing is truncated.
module multiplier_4_x_4
   import dot_product_acc_pkg::*;
(
   input  logic [OPND_W-1:0] inp1,
   input  logic [OPND_W-1:0] inp2,
   output logic [PROD_W-1:0] product
);

   assign product = PROD_W'(inp1) * PROD_W'(inp2);

endmodule

// File: rtl/dot_product_acc.sv
// Streaming dot product of VEC_LEN unsigned 4-bit pairs.
// A registered product stage feeds an inline accumulator; the result is held until it is taken.
module dot_product_acc
   import dot_product_acc_pkg::*;
#(
   parameter int VEC_LEN = DEF_VEC_LEN,
   parameter int ACC_W   = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum
);

   localparam int     CNT_W   = $clog2(VEC_LEN + 1);
   localparam longint MAX_SUM = longint'(VEC_LEN) * 225;

   if (VEC_LEN < 2 || VEC_LEN > 255) begin : g_len_chk
      $error("dot_product_acc: VEC_LEN must be in 2..255");
   end
   if (ACC_W < PROD_W + $clog2(VEC_LEN) || MAX_SUM >= (longint'(1) << ACC_W)) begin : g_width_chk
      $error("dot_product_acc: ACC_W too narrow for VEC_LEN*225");
   end

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PROD_W-1:0]  prod_q, prod_d;
   logic               prod_v_q, prod_v_d;
   logic [PROD_W-1:0]  mult;

   multiplier_4_x_4 u_mult (
      .product (mult),
      .inp1    (a),
      .inp2    (b)
   );

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      count_d   = count_q;
      prod_d    = prod_q;
      prod_v_d  = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      if (prod_v_q) begin
         acc_d = acc_q + ACC_W'(prod_q);
      end

      case (state_q)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               prod_d   = mult;
               prod_v_d = 1'b1;
               count_d  = count_q + CNT_W'(1);
               if (count_q == CNT_W'(VEC_LEN - 1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               acc_d   = '0;
               count_d = '0;
               state_d = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ACCUM;
         acc_q    <= '0;
         count_q  <= '0;
         prod_q   <= '0;
         prod_v_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         prod_q   <= prod_d;
         prod_v_q <= prod_v_d;
      end
   end

   assign out_sum = acc_q;

endmodule
